result_monitor: RTL and testbench

RESULT_MONITOR -- requirements
Module: result_monitor

---
 rtl/result_monitor_pkg.sv | 51 +++++
 rtl/result_monitor_seg7_decode.sv | 11 +
 rtl/result_monitor.sv | 100 ++++++++++
 tb/tb_result_monitor.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/result_monitor_pkg.sv
// rtl/result_monitor_pkg.sv - shared types, light codes and 7-segment table for result_monitor
package result_monitor_pkg;

  typedef enum logic [2:0] {
    ST_SYNC   = 3'd0,
    ST_EXP_RA = 3'd1,
    ST_EXP_G  = 3'd2,
    ST_EXP_A  = 3'd3,
    ST_EXP_R  = 3'd4
  } light_state_e;

  localparam logic [2:0] LIGHT_RED     = 3'b100;
  localparam logic [2:0] LIGHT_RED_AMB = 3'b110;
  localparam logic [2:0] LIGHT_GRN     = 3'b001;
  localparam logic [2:0] LIGHT_AMB     = 3'b010;

  localparam logic [2:0] DICE_ILLEGAL  = 3'd7;

  // Segments {g,f,e,d,c,b,a}, indexed by face; 0 and 7 are blank.
  localparam logic [7:0][6:0] SEG_TABLE = {
    7'b0000000,
    7'b1111101,
    7'b1101101,
    7'b1100110,
    7'b1001111,
    7'b1011011,
    7'b0000110,
    7'b0000000
  };

  function automatic logic [2:0] expected_code(input light_state_e st);
    case (st)
      ST_EXP_RA: expected_code = LIGHT_RED_AMB;
      ST_EXP_G:  expected_code = LIGHT_GRN;
      ST_EXP_A:  expected_code = LIGHT_AMB;
      ST_EXP_R:  expected_code = LIGHT_RED;
      default:   expected_code = LIGHT_RED;
    endcase
  endfunction

  function automatic light_state_e next_state(input light_state_e st);
    case (st)
      ST_EXP_RA: next_state = ST_EXP_G;
      ST_EXP_G:  next_state = ST_EXP_A;
      ST_EXP_A:  next_state = ST_EXP_R;
      ST_EXP_R:  next_state = ST_EXP_RA;
      default:   next_state = ST_SYNC;
    endcase
  endfunction

endpackage

// File: rtl/result_monitor_seg7_decode.sv
// rtl/result_monitor_seg7_decode.sv - combinational dice face to 7-segment decoder
module seg7_decode
  import result_monitor_pkg::*;
(
  input  logic [2:0] face_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[face_i];

endmodule

// File: rtl/result_monitor.sv
// rtl/result_monitor.sv - checks traffic-light sequence or latches dice throws, counts errors/throws
module result_monitor
  import result_monitor_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             button,
  input  logic [2:0]       result,
  output logic [2:0]       face,
  output logic [6:0]       seg,
  output logic             seq_err,
  output logic             face_err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] throw_count
);

  localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

  light_state_e     state_q, state_d;
  logic             button_q;
  logic [2:0]       face_q, face_d;
  logic [6:0]       seg_q, seg_d;
  logic             seq_err_q, seq_err_d;
  logic             face_err_q, face_err_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] throw_count_q, throw_count_d;
  logic             throw_d;
  logic [CNT_W:0]   err_sum;

  // Light checker: leaving light mode always drops sync, so a fresh red is needed.
  always_comb begin
    state_d   = state_q;
    seq_err_d = 1'b0;
    if (!sel) begin
      state_d = ST_SYNC;
    end else if (state_q == ST_SYNC) begin
      if (result == LIGHT_RED) state_d = ST_EXP_RA;
    end else if (result == expected_code(state_q)) begin
      state_d = next_state(state_q);
    end else begin
      seq_err_d = 1'b1;
      state_d   = (result == LIGHT_RED) ? ST_EXP_RA : ST_SYNC;
    end
  end

  always_comb begin
    face_err_d = !sel && (result == DICE_ILLEGAL);
    throw_d    = button_q && !button && !sel &&
                 (result != 3'd0) && (result != DICE_ILLEGAL);
    face_d     = throw_d ? result : face_q;
  end

  // Both error sources may add in one cycle; clamp the widened sum.
  always_comb begin
    err_sum = {1'b0, err_count_q} + (CNT_W+1)'(seq_err_d) + (CNT_W+1)'(face_err_d);
    err_count_d = (err_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : err_sum[CNT_W-1:0];
    throw_count_d = throw_count_q;
    if (throw_d && (throw_count_q != {CNT_W{1'b1}})) begin
      throw_count_d = throw_count_q + 1'b1;
    end
  end

  seg7_decode u_seg7_decode (
    .face_i (face_d),
    .seg_o  (seg_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_SYNC;
      button_q      <= 1'b0;
      face_q        <= 3'd0;
      seg_q         <= 7'd0;
      seq_err_q     <= 1'b0;
      face_err_q    <= 1'b0;
      err_count_q   <= '0;
      throw_count_q <= '0;
    end else begin
      state_q       <= state_d;
      button_q      <= button;
      face_q        <= face_d;
      seg_q         <= seg_d;
      seq_err_q     <= seq_err_d;
      face_err_q    <= face_err_d;
      err_count_q   <= err_count_d;
      throw_count_q <= throw_count_d;
    end
  end

  assign face        = face_q;
  assign seg         = seg_q;
  assign seq_err     = seq_err_q;
  assign face_err    = face_err_q;
  assign err_count   = err_count_q;
  assign throw_count = throw_count_q;

endmodule

// File: tb/tb_result_monitor.sv
// tb/tb_result_monitor.sv - self-checking bench for result_monitor (CNT_W=8 and CNT_W=2 instances)
module tb_result_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       button = 1'b0;
  logic [2:0] result = 3'd0;

  logic [2:0] face_a, face_b;
  logic [6:0] seg_a, seg_b;
  logic       seq_err_a, seq_err_b, face_err_a, face_err_b;
  logic [7:0] err_count_a, throw_count_a;
  logic [1:0] err_count_b, throw_count_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  result_monitor #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .sel(sel), .button(button), .result(result),
    .face(face_a), .seg(seg_a), .seq_err(seq_err_a), .face_err(face_err_a),
    .err_count(err_count_a), .throw_count(throw_count_a)
  );

  result_monitor #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .sel(sel), .button(button), .result(result),
    .face(face_b), .seg(seg_b), .seq_err(seq_err_b), .face_err(face_err_b),
    .err_count(err_count_b), .throw_count(throw_count_b)
  );

  // Reference model: light cycle as a list position, counts as unbounded ints.
  int         m_cycle [4] = '{6, 1, 2, 4};
  bit         m_synced;
  int         m_pos;
  bit         m_btn;
  int         m_face, m_err, m_thr;
  bit         m_seq, m_ferr;
  bit         model_valid = 1'b0;

  function automatic int seg_of(input int f);
    case (f)
      1: seg_of = 7'b0000110;
      2: seg_of = 7'b1011011;
      3: seg_of = 7'b1001111;
      4: seg_of = 7'b1100110;
      5: seg_of = 7'b1101101;
      6: seg_of = 7'b1111101;
      default: seg_of = 0;
    endcase
  endfunction

  function automatic int sat(input int v, input int maxv);
    sat = (v > maxv) ? maxv : v;
  endfunction

  task automatic model_step(input bit r, input bit s, input bit b, input int res);
    if (r) begin
      m_synced = 0; m_pos = 0; m_btn = 0; m_face = 0;
      m_err = 0; m_thr = 0; m_seq = 0; m_ferr = 0;
    end else begin
      m_seq  = 0;
      m_ferr = !s && (res == 7);
      if (!s) begin
        m_synced = 0;
      end else if (!m_synced) begin
        if (res == 4) begin m_synced = 1; m_pos = 0; end
      end else if (res == m_cycle[m_pos]) begin
        m_pos = (m_pos + 1) % 4;
      end else begin
        m_seq = 1;
        if (res == 4) m_pos = 0; else m_synced = 0;
      end
      if (m_btn && !b && !s && res >= 1 && res <= 6) begin
        m_face = res;
        m_thr++;
      end
      m_err = m_err + int'(m_seq) + int'(m_ferr);
      m_btn = b;
    end
    model_valid = 1'b1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      chk("face",         int'(face_a),        m_face);
      chk("seg",          int'(seg_a),         seg_of(m_face));
      chk("seq_err",      int'(seq_err_a),     int'(m_seq));
      chk("face_err",     int'(face_err_a),    int'(m_ferr));
      chk("err_count",    int'(err_count_a),   sat(m_err, 255));
      chk("throw_count",  int'(throw_count_a), sat(m_thr, 255));
      chk("w2_face",      int'(face_b),        m_face);
      chk("w2_seg",       int'(seg_b),         seg_of(m_face));
      chk("w2_err_count", int'(err_count_b),   sat(m_err, 3));
      chk("w2_throw",     int'(throw_count_b), sat(m_thr, 3));
      chk("errs_exclusive", int'(seq_err_a && face_err_a), 0);
    end
  end

  task automatic cyc(input bit r, input bit s, input bit b, input int res);
    rst = r; sel = s; button = b; result = 3'(res);
    @(posedge clk);
    model_step(r, s, b, res);
    @(negedge clk);
  endtask

  task automatic throw_once(input int res);
    cyc(0, 0, 1, res);
    cyc(0, 0, 0, res);
  endtask

  initial begin
    // reset state
    cyc(1, 0, 0, 0);
    chk("rst_face", int'(face_a), 0);
    chk("rst_seg", int'(seg_a), 0);
    chk("rst_counts", int'(err_count_a) + int'(throw_count_a), 0);

    // Scenario 1: clean light cycle
    cyc(0, 1, 0, 4); cyc(0, 1, 0, 6); cyc(0, 1, 0, 1); cyc(0, 1, 0, 2); cyc(0, 1, 0, 4);
    cyc(0, 1, 0, 6);
    chk("s1_err_count", int'(err_count_a), 0);

    // Scenario 2: amber while expecting green
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 4); cyc(0, 1, 0, 6); cyc(0, 1, 0, 2);
    chk("s2_seq_err", int'(seq_err_a), 1);
    chk("s2_err_count", int'(err_count_a), 1);
    cyc(0, 1, 0, 6);
    chk("s2_sync_no_err", int'(seq_err_a), 0);
    cyc(0, 1, 0, 4); cyc(0, 1, 0, 6); cyc(0, 1, 0, 1); cyc(0, 1, 0, 2);
    chk("s2_resumed", int'(err_count_a), 1);
    cyc(0, 1, 0, 1);
    chk("s2_second_err", int'(err_count_a), 2);

    // Scenario 3: throw of 5
    cyc(1, 0, 0, 0);
    throw_once(5);
    chk("s3_face", int'(face_a), 5);
    chk("s3_seg", int'(seg_a), 7'b1101101);
    chk("s3_throw", int'(throw_count_a), 1);

    // Scenario 4: illegal code 7 for 3 cycles with a button fall
    cyc(0, 0, 1, 7); cyc(0, 0, 0, 7); cyc(0, 0, 0, 7);
    cyc(0, 0, 0, 0);
    chk("s4_err_count", int'(err_count_a), 3);
    chk("s4_face", int'(face_a), 5);
    chk("s4_throw", int'(throw_count_a), 1);

    // fall with result 0 or sel=1 does not throw; face held across mode change
    throw_once(0);
    cyc(0, 1, 1, 3); cyc(0, 1, 0, 3);
    cyc(0, 0, 0, 0);
    chk("no_throw_face", int'(face_a), 5);
    chk("no_throw_cnt", int'(throw_count_a), 1);

    // sel drop mid-sequence forces resync
    cyc(0, 1, 0, 4); cyc(0, 1, 0, 6); cyc(0, 0, 0, 0); cyc(0, 1, 0, 1);
    chk("sel_resync", int'(seq_err_a), 0);

    // Scenario 5: saturation at CNT_W=2
    cyc(1, 0, 0, 0);
    throw_once(1); throw_once(2); throw_once(3); throw_once(6); throw_once(4);
    chk("s5_w2_throw", int'(throw_count_b), 3);
    chk("s5_w8_throw", int'(throw_count_a), 5);
    chk("s5_face", int'(face_a), 4);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 7);
    chk("s5_w2_err", int'(err_count_b), 3);
    chk("s5_w8_err", int'(err_count_a), 5);

    // Scenario 6: reset wins over a button fall
    cyc(0, 0, 1, 4);
    cyc(1, 0, 0, 4);
    chk("s6_face", int'(face_a), 0);
    chk("s6_throw", int'(throw_count_a), 0);
    chk("s6_err", int'(err_count_a), 0);
    cyc(0, 0, 0, 4);
    chk("s6_after_face", int'(face_a), 0);

    // reset mid-sequence needs a fresh red
    cyc(0, 1, 0, 4); cyc(0, 1, 0, 6);
    cyc(1, 1, 0, 1);
    cyc(0, 1, 0, 1); cyc(0, 1, 0, 2);
    chk("rst_mid_no_err", int'(err_count_a), 0);
    cyc(0, 1, 0, 4); cyc(0, 1, 0, 4);
    chk("rst_mid_rechecks", int'(err_count_a), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
